// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared helpers for pipelined_prefix_adder: prefix depth, pipeline latency, op encoding.
package pipelined_prefix_adder_pkg;

  typedef enum logic {
    PPA_ADD = 1'b0,
    PPA_SUB = 1'b1
  } ppa_op_e;

  function automatic int ppa_levels(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic int ppa_latency(input int width, input int reg_every);
    return 2 + (ppa_levels(width) - 1) / reg_every;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One Kogge-Stone level: combines each bit's (P,G) with the bit SPAN below it.
module ppa_prefix_level
  import pipelined_prefix_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p_grp,
  output logic [WIDTH-1:0] g_grp
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_comb
      assign g_grp[i] = g[i] | (p[i] & g[i-SPAN]);
      assign p_grp[i] = p[i] & p[i-SPAN];
    end else begin : g_pass
      assign g_grp[i] = g[i];
      assign p_grp[i] = p[i];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Valid/ready pipelined Kogge-Stone adder/subtractor with a register every REG_EVERY levels.
// Optional saturation on signed overflow via `define PIPELINED_PREFIX_ADDER_SAT_EN.
module pipelined_prefix_adder
  import pipelined_prefix_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = ppa_levels(WIDTH);
  localparam int LAT    = ppa_latency(WIDTH, REG_EVERY);
  localparam int STAGES = LAT - 1;  // index of the output register
  localparam int NMID   = LAT - 2;  // index of the last prefix register

  logic [STAGES:0]            vld_pipe, vin, ld;
  logic [NMID:0][WIDTH-1:0]   g_q, p_q, h_q, d_g, d_p, d_h;
  logic [NMID:0]              c0_q, amsb_q, sat_q, d_c0, d_amsb, d_sat;
  logic [LEVELS-1:0][WIDTH-1:0] tg, tp;
  logic [LEVELS:1][WIDTH-1:0] lg, lp;
  logic                       sat_w;
  ppa_op_e                    op;
  logic [WIDTH-1:0]           bx, cy, s_w, res_w;
  logic                       ovf_w;

`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
  assign sat_w = sat;
`else
  assign sat_w = 1'b0;
`endif

  // Stage-0 capture: h keeps the raw half-sum, p/g start the prefix tree.
  assign op        = ppa_op_e'(sub);
  assign bx        = (op == PPA_SUB) ? ~B : B;
  assign d_g[0]    = A & bx;
  assign d_p[0]    = A ^ bx;
  assign d_h[0]    = A ^ bx;
  assign d_c0[0]   = (op == PPA_SUB) ? 1'b1 : cin;
  assign d_amsb[0] = A[WIDTH-1];
  assign d_sat[0]  = sat_w;

  for (genvar k = 1; k <= NMID; k++) begin : g_mid
    assign d_g[k]    = lg[k*REG_EVERY];
    assign d_p[k]    = lp[k*REG_EVERY];
    assign d_h[k]    = h_q[k-1];
    assign d_c0[k]   = c0_q[k-1];
    assign d_amsb[k] = amsb_q[k-1];
    assign d_sat[k]  = sat_q[k-1];
  end

  for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
    if (s % REG_EVERY == 0) begin : g_reg
      assign tg[s] = g_q[s/REG_EVERY];
      assign tp[s] = p_q[s/REG_EVERY];
    end else begin : g_wire
      assign tg[s] = lg[s];
      assign tp[s] = lp[s];
    end
    ppa_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << s)) u_lvl (
      .p    (tp[s]),
      .g    (tg[s]),
      .p_grp(lp[s+1]),
      .g_grp(lg[s+1])
    );
  end

  // A stage loads when it or anything downstream of it has room.
  assign vin = {vld_pipe[STAGES-1:0], in_valid};
  for (genvar k = 0; k <= STAGES; k++) begin : g_ld
    assign ld[k] = out_ready | ~(&vld_pipe[STAGES:k]);
  end
  assign in_ready  = ld[0];
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      for (int k = 0; k <= STAGES; k++)
        if (ld[k]) vld_pipe[k] <= vin[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k <= NMID; k++) begin
      if (ld[k] && vin[k]) begin
        g_q[k]    <= d_g[k];
        p_q[k]    <= d_p[k];
        h_q[k]    <= d_h[k];
        c0_q[k]   <= d_c0[k];
        amsb_q[k] <= d_amsb[k];
        sat_q[k]  <= d_sat[k];
      end
    end
  end

  always_comb begin
    cy    = lg[LEVELS] | (lp[LEVELS] & {WIDTH{c0_q[NMID]}});
    s_w   = h_q[NMID] ^ {cy[WIDTH-2:0], c0_q[NMID]};
    // Operands share a sign exactly when their half-sum MSB is 0.
    ovf_w = ~h_q[NMID][WIDTH-1] & (s_w[WIDTH-1] ^ amsb_q[NMID]);
    res_w = s_w;
    if (sat_q[NMID] && ovf_w)
      res_w = amsb_q[NMID] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (ld[STAGES] && vin[STAGES]) begin
      sum  <= res_w;
      cout <= cy[WIDTH-1];
      ovf  <= ovf_w;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for pipelined_prefix_adder at WIDTH=16, REG_EVERY=2 (latency 3).
module tb_pipelined_prefix_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
  logic         sat = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] VA  [8] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h0005, 16'h8000, 16'h0000, 16'h00FF};
  localparam logic [15:0] VB  [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h8000, 16'h0000, 16'h0F01};
  localparam logic        VC  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        VS  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] VSW [8] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h5556, 16'hFFFE, 16'h0000, 16'h0000, 16'h1001};
  localparam logic        VCO [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic        VOV [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
  localparam logic        VSAT[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [15:0] VSS [8] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h5556, 16'hFFFE, 16'h8000, 16'h0000, 16'h1001};
`endif

  localparam logic [15:0] BB_A[8] = '{16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707};
  localparam logic [15:0] BB_S[8] = '{16'h1000, 16'h1101, 16'h1202, 16'h1303, 16'h1404, 16'h1505, 16'h1606, 16'h1707};

  always #5 clk = ~clk;

  pipelined_prefix_adder #(.WIDTH(W), .REG_EVERY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .sub      (sub),
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_out_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL rst_sum: got %h want 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b want 0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors;
    logic [15:0] exp_s;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = VA[i]; B = VB[i]; cin = VC[i]; sub = VS[i];
      exp_s = VSW[i];
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
      sat = VSAT[i];
      if (VSAT[i]) exp_s = VSS[i];
`endif
      in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready); end
      tick;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early1: out_valid %b want 0", i, out_valid); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early2: out_valid %b want 0", i, out_valid); end
      tick;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency: out_valid %b want 1", i, out_valid); end
      n_cmp++; if (sum !== exp_s) begin n_bad++; $display("FAIL vec%0d_sum: got %h want %h", i, sum, exp_s); end
      n_cmp++; if (cout !== VCO[i]) begin n_bad++; $display("FAIL vec%0d_cout: got %b want %b", i, cout, VCO[i]); end
      n_cmp++; if (ovf !== VOV[i]) begin n_bad++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, VOV[i]); end
      tick;
    end
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
    sat = 1'b0;
`endif
    cin = 1'b0; sub = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc, pops, first, last;
    logic rdy, ov;
    logic [15:0] sv;
    acc = 0; pops = 0; first = -1; last = -1;
    B = 16'h1000; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      A = BB_A[acc < 8 ? acc : 7];
      #1;
      rdy = in_ready;
      if (out_valid === 1'b1) begin
        n_cmp++; if (sum !== BB_S[0]) begin n_bad++; $display("FAIL bb_hold_sum: got %h want %h", sum, BB_S[0]); end
      end
      tick;
      if (rdy) acc++;
    end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL bb_accepted: got %0d want 3", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bb_full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bb_full_out_valid: got %b want 1", out_valid); end

    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bb_push_pop_in_ready: got %b want 1", in_ready); end
    for (int cyc = 0; cyc < 20 && pops < 8; cyc++) begin
      in_valid = (acc < 8);
      if (acc < 8) A = BB_A[acc];
      #1;
      rdy = in_ready; ov = out_valid; sv = sum;
      if (ov === 1'b1) begin
        n_cmp++; if (sv !== BB_S[pops]) begin n_bad++; $display("FAIL bb_order%0d: got %h want %h", pops, sv, BB_S[pops]); end
        if (first < 0) first = cyc;
        last = cyc;
        pops++;
      end
      tick;
      if (in_valid && rdy) acc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (pops != 8) begin n_bad++; $display("FAIL bb_pop_count: got %0d want 8", pops); end
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL bb_acc_count: got %0d want 8", acc); end
    n_cmp++; if (last - first != 7) begin n_bad++; $display("FAIL bb_throughput: span %0d cycles want 7", last - first); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bb_drained: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_flush;
    out_ready = 1'b0;
    cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; A = 16'h0100; B = 16'h0200;
    tick;
    A = 16'h0300; B = 16'h0400;
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_out_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_async_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL flush_async_sum: got %h want 0000", sum); end
    tick; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_during_out_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale%0d: out_valid %b want 0", c, out_valid); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; A = 16'h0003; B = 16'h0004;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_early1: out_valid %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_early2: out_valid %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_latency: out_valid %b want 1", out_valid); end
    n_cmp++; if (sum !== 16'h0007) begin n_bad++; $display("FAIL flush_sum: got %h want 0007", sum); end
    tick;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
